box_cmd_scheduler: RTL

- Queues box-draw commands from the keypad/game logic and sequences them onto the VGA adapter pixel-write port.
- Each command is either a fixed-size coloured box at (X,Y) or a full-screen clear to black.
- Contains a command FIFO plus a raster walker that emits one pixel write per cycle. It replaces ad-hoc per-lab draw FSMs in front of the VGA adapter.

---
 rtl/box_cmd_scheduler_pkg.sv | 27 ++
 rtl/box_cmd_scheduler_if.sv | 28 ++
 rtl/box_cmd_scheduler_fifo.sv | 61 ++++++
 rtl/box_cmd_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/box_cmd_scheduler_pkg.sv
// Shared types and screen constants for the box command scheduler.
package box_sched_pkg;

    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;

    localparam int unsigned BOX_W_DEFAULT = 4;
    localparam int unsigned BOX_H_DEFAULT = 4;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } schedState_t;

    typedef struct packed {
        logic       clear;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } cmdEntry_t;

    localparam int unsigned ENTRY_W = $bits(cmdEntry_t);

endpackage

// File: rtl/box_cmd_scheduler_if.sv
// Command handshake and pixel-write bus between game logic, scheduler and VGA adapter.
interface box_cmd_scheduler_if #(
    parameter int unsigned LEVEL_W = 3
);
    logic               iCmdValid;
    logic               oCmdReady;
    logic [7:0]         iCmdX;
    logic [6:0]         iCmdY;
    logic [2:0]         iCmdColour;
    logic               iCmdClear;
    logic [7:0]         oX;
    logic [6:0]         oY;
    logic [2:0]         oColour;
    logic               oPlot;
    logic               oBusy;
    logic               oDone;
    logic [LEVEL_W-1:0] oLevel;

    modport master (
        output iCmdValid, iCmdX, iCmdY, iCmdColour, iCmdClear,
        input  oCmdReady, oX, oY, oColour, oPlot, oBusy, oDone, oLevel
    );

    modport slave (
        input  iCmdValid, iCmdX, iCmdY, iCmdColour, iCmdClear,
        output oCmdReady, oX, oY, oColour, oPlot, oBusy, oDone, oLevel
    );
endinterface

// File: rtl/box_cmd_scheduler_fifo.sv
// Synchronous command FIFO; read data is registered and valid the cycle after pop.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 19
) (
    input  logic                     iClock,
    input  logic                     iResetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [LEVEL_W-1:0] count;
    logic               doPush;
    logic               doPop;

    assign full   = (count == LEVEL_W'(DEPTH));
    assign empty  = (count == '0);
    assign level  = count;
    // A full FIFO refuses pushes even when a pop frees a slot this same cycle.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge iClock) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            rdData <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdData <= mem[rdPtr];
                rdPtr  <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + LEVEL_W'(1);
                2'b01:   count <= count - LEVEL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/box_cmd_scheduler.sv
// Queues box/clear commands and walks each one out as one pixel write per cycle.
module box_cmd_scheduler
    import box_sched_pkg::*;
#(
    parameter logic [7:0]  X_SCREEN_PIXELS = SCREEN_W,
    parameter logic [6:0]  Y_SCREEN_PIXELS = SCREEN_H,
    parameter int unsigned BOX_W           = BOX_W_DEFAULT,
    parameter int unsigned BOX_H           = BOX_H_DEFAULT,
    parameter int unsigned DEPTH           = DEPTH_DEFAULT
) (
    input  logic              iClock,
    input  logic              iResetn,
    box_cmd_scheduler_if.slave bus
);
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

    schedState_t        state;
    schedState_t        stateNext;
    cmdEntry_t          wrEntry;
    cmdEntry_t          rdEntry;
    cmdEntry_t          curEntry;
    cmdEntry_t          srcEntry;
    logic [ENTRY_W-1:0] rdBits;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [LEVEL_W-1:0] fifoLevel;
    logic               pop;
    logic               load;
    logic               drawNext;
    logic               doneNext;
    logic               lastX;
    logic               lastY;
    logic [7:0]         cx;
    logic [7:0]         cxNext;
    logic [7:0]         limX;
    logic [6:0]         cy;
    logic [6:0]         cyNext;
    logic [6:0]         limY;
    logic [8:0]         xSum;
    logic [7:0]         ySum;
    logic [2:0]         colourNext;
    logic               inScreen;
    logic [7:0]         xReg;
    logic [6:0]         yReg;
    logic [2:0]         colourReg;
    logic               plotReg;
    logic               doneReg;

    assign wrEntry = {bus.iCmdClear, bus.iCmdX, bus.iCmdY, bus.iCmdColour};
    assign rdEntry = cmdEntry_t'(rdBits);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .iClock  (iClock),
        .iResetn (iResetn),
        .push    (bus.iCmdValid),
        .pop     (pop),
        .wrData  (wrEntry),
        .rdData  (rdBits),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .level   (fifoLevel)
    );

    assign limX  = curEntry.clear ? (X_SCREEN_PIXELS - 8'd1) : 8'(BOX_W - 1);
    assign limY  = curEntry.clear ? (Y_SCREEN_PIXELS - 7'd1) : 7'(BOX_H - 1);
    assign lastX = (cx == limX);
    assign lastY = (cy == limY);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // cx/cy always name the pixel currently shown on the output registers.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        load      = 1'b0;
        drawNext  = 1'b0;
        doneNext  = 1'b0;
        cxNext    = cx;
        cyNext    = cy;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                load      = 1'b1;
                drawNext  = 1'b1;
                cxNext    = '0;
                cyNext    = '0;
                stateNext = DRAW;
            end
            DRAW: begin
                if (lastX && lastY) begin
                    doneNext  = 1'b1;
                    stateNext = DONE;
                end else begin
                    drawNext = 1'b1;
                    if (lastX) begin
                        cxNext = '0;
                        cyNext = cy + 7'd1;
                    end else begin
                        cxNext = cx + 8'd1;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Sums are widened so off-screen pixels clip instead of wrapping to the left edge.
    always_comb begin
        srcEntry = load ? rdEntry : curEntry;
        if (srcEntry.clear) begin
            xSum       = {1'b0, cxNext};
            ySum       = {1'b0, cyNext};
            colourNext = 3'd0;
        end else begin
            xSum       = {1'b0, srcEntry.x} + {1'b0, cxNext};
            ySum       = {1'b0, srcEntry.y} + {1'b0, cyNext};
            colourNext = srcEntry.colour;
        end
        inScreen = (xSum < {1'b0, X_SCREEN_PIXELS}) && (ySum < {1'b0, Y_SCREEN_PIXELS});
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            cx        <= '0;
            cy        <= '0;
            curEntry  <= '0;
            xReg      <= '0;
            yReg      <= '0;
            colourReg <= '0;
            plotReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            cx      <= cxNext;
            cy      <= cyNext;
            plotReg <= drawNext && inScreen;
            doneReg <= doneNext;
            if (load) begin
                curEntry <= rdEntry;
            end
            if (drawNext) begin
                xReg      <= xSum[7:0];
                yReg      <= ySum[6:0];
                colourReg <= colourNext;
            end
        end
    end

    assign bus.oX        = xReg;
    assign bus.oY        = yReg;
    assign bus.oColour   = colourReg;
    assign bus.oPlot     = plotReg;
    assign bus.oDone     = doneReg;
    assign bus.oCmdReady = !fifoFull;
    assign bus.oLevel    = fifoLevel;
    assign bus.oBusy     = (state == LOAD) || (state == DRAW) || !fifoEmpty;

endmodule
